flash_read_cache: RTL

- Direct-mapped, read-only word cache between the CPU instruction/data fetch port and the memory-mapped SPI flash read controller.
- Hits return data one cycle after the strobe. A miss issues exactly one 32-bit flash read, which takes several thousand cycles at the ~500 kHz SPI rate.
- It then fills the line and returns the word.
- The flash controller's `rdata` is already byte-swapped to CPU order; this block passes it through unchanged.

---
 rtl/flash_cache_pkg.sv | 13 +
 rtl/flash_cache_array.sv | 49 ++++
 rtl/flash_read_cache.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/flash_cache_pkg.sv
// rtl/flash_cache_pkg.sv - shared widths and FSM state type for the flash read cache
package flash_cache_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/flash_cache_array.sv
// rtl/flash_cache_array.sv - valid/tag/data storage, combinational read, one write port, clear-all
module flash_cache_array
    import flash_cache_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Flush wins over a coincident write so a fill racing a flush never leaves a valid line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/flash_read_cache.sv
// rtl/flash_read_cache.sv - direct-mapped word cache in front of the SPI flash reader; FLASH_CACHE_STATS_EN adds hit/miss counters
module flash_read_cache
    import flash_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rstrb,
    input  logic [ADDR_W-1:0] cpu_word_address,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rbusy,
    input  logic              cache_flush,
    output logic              flash_rstrb,
    output logic [ADDR_W-1:0] flash_word_address,
    input  logic [DATA_W-1:0] flash_rdata,
    input  logic              flash_rbusy
`ifdef FLASH_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_e            state_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_rbusy_q;
    logic              flash_rstrb_q;
    logic [ADDR_W-1:0] flash_addr_q;
    logic              fill_dropped_q;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit_c;
    logic              req_c;
    logic              fill_done_c;
    logic              wr_en_c;

    // A flush on the strobe cycle invalidates the line being looked up, so it must miss.
    assign req_c       = (state_q == IDLE) && cpu_rstrb;
    assign hit_c       = rd_valid && (rd_tag == cpu_word_address[ADDR_W-1:IDX_W]) && !cache_flush;
    assign fill_done_c = (state_q == WAIT) && !flash_rbusy;
    assign wr_en_c     = fill_done_c && !fill_dropped_q;

    flash_cache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .flush    (cache_flush),
        .rd_idx   (cpu_word_address[IDX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en_c),
        .wr_idx   (flash_addr_q[IDX_W-1:0]),
        .wr_tag   (flash_addr_q[ADDR_W-1:IDX_W]),
        .wr_data  (flash_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cpu_rdata_q    <= '0;
            cpu_rbusy_q    <= 1'b0;
            flash_rstrb_q  <= 1'b0;
            flash_addr_q   <= '0;
            fill_dropped_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        if (hit_c) begin
                            cpu_rdata_q <= rd_data;
                        end else begin
                            flash_addr_q   <= cpu_word_address;
                            cpu_rbusy_q    <= 1'b1;
                            flash_rstrb_q  <= 1'b1;
                            fill_dropped_q <= 1'b0;
                            state_q        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cache_flush) begin
                        fill_dropped_q <= 1'b1;
                    end
                    // Strobe is held through the controller's START cycle until it reports busy.
                    if (flash_rbusy) begin
                        flash_rstrb_q <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cache_flush) begin
                        fill_dropped_q <= 1'b1;
                    end
                    if (!flash_rbusy) begin
                        cpu_rdata_q <= flash_rdata;
                        cpu_rbusy_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata          = cpu_rdata_q;
    assign cpu_rbusy          = cpu_rbusy_q;
    assign flash_rstrb        = flash_rstrb_q;
    assign flash_word_address = flash_addr_q;

`ifdef FLASH_CACHE_STATS_EN
    logic [31:0] stat_hits_q;
    logic [31:0] stat_misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (req_c) begin
            if (hit_c) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end else begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule
